// File: rtl/valve_hv_scheduler.sv
// HV boost scheduler: holds commanded valves on LV and boosts newly opened valves
// in round-robin groups of at most MAX_GROUP, with a supply-recovery gap between groups.
module valve_hv_scheduler #(
   parameter int CHANNEL_NUM = 48,
   parameter int MAX_GROUP   = 8,
   parameter int HV_TIME     = 4000,
   parameter int GAP_TIME    = 200,
   parameter int IDX_W       = 6
) (
   input  logic                   sys_clk,
   input  logic                   rst_n,
   input  logic                   fault,
   input  logic                   frame_valid,
   input  logic [CHANNEL_NUM-1:0] frame_open,
   output logic [CHANNEL_NUM-1:0] lv_on,
   output logic [CHANNEL_NUM-1:0] hv_on,
   output logic                   busy,
   output logic [IDX_W:0]         backlog
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_BOOST = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CHANNEL_NUM - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W + 1)'(1);
   localparam logic [IDX_W:0]   CH_TOTAL  = (IDX_W + 1)'(CHANNEL_NUM);
   localparam logic [IDX_W:0]   GRP_FULL  = (IDX_W + 1)'(MAX_GROUP);
   localparam logic [31:0]      HV_LOAD   = 32'(HV_TIME - 1);
   localparam logic [31:0]      GAP_LOAD  = 32'(GAP_TIME - 1);

   function automatic logic [IDX_W:0] popcount(input logic [CHANNEL_NUM-1:0] v);
      logic [IDX_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         cnt = cnt + {{IDX_W{1'b0}}, v[i]};
      end
      return cnt;
   endfunction

   state_t                 state_r, state_s;
   logic [CHANNEL_NUM-1:0] cur_open_r, cur_open_s;
   logic [CHANNEL_NUM-1:0] pending_r, pending_s;
   logic [CHANNEL_NUM-1:0] group_r, group_s;
   logic [CHANNEL_NUM-1:0] grant_s;
   logic [IDX_W-1:0]       idx_r, idx_s, idx_inc_s;
   logic [IDX_W-1:0]       rr_ptr_r, rr_ptr_s;
   logic [IDX_W:0]         scanned_r, scanned_s;
   logic [31:0]            hv_cnt_r, hv_cnt_s;
   logic [31:0]            gap_cnt_r, gap_cnt_s;

   assign idx_inc_s = (idx_r == LAST_IDX) ? '0 : idx_r + IDX_ONE;

   // Next-state computation: FSM step, then frame merge, then scan-exit decision on the merged group.
   always_comb begin
      state_s    = state_r;
      cur_open_s = cur_open_r;
      group_s    = group_r;
      idx_s      = idx_r;
      rr_ptr_s   = rr_ptr_r;
      scanned_s  = scanned_r;
      hv_cnt_s   = hv_cnt_r;
      gap_cnt_s  = gap_cnt_r;
      grant_s    = '0;

      case (state_r)
         ST_IDLE: begin
            if (pending_r != '0) begin
               state_s   = ST_SCAN;
               idx_s     = rr_ptr_r;
               scanned_s = '0;
               group_s   = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (pending_r[idx_r]) begin
               grant_s[idx_r] = 1'b1;
               group_s[idx_r] = 1'b1;
               rr_ptr_s       = idx_inc_s;
            end else begin
               rr_ptr_s = rr_ptr_r;
            end
            idx_s     = idx_inc_s;
            scanned_s = scanned_r + CNT_ONE;
         end
         ST_BOOST: begin
            if (hv_cnt_r == 32'd0) begin
               state_s   = ST_GAP;
               gap_cnt_s = GAP_LOAD;
            end else begin
               hv_cnt_s = hv_cnt_r - 32'd1;
            end
         end
         ST_GAP: begin
            if (gap_cnt_r == 32'd0) begin
               state_s = ST_IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r - 32'd1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Closing a valve drops it from both queues; only closed->open edges are (re)queued.
      pending_s = pending_r & ~grant_s;
      if (frame_valid) begin
         pending_s  = (pending_s & frame_open) | (frame_open & ~cur_open_r);
         group_s    = group_s & frame_open;
         cur_open_s = frame_open;
      end else begin
         cur_open_s = cur_open_r;
      end

      if (state_r == ST_SCAN) begin
         if ((popcount(group_s) >= GRP_FULL) || (scanned_s == CH_TOTAL)) begin
            if (group_s == '0) begin
               state_s = ST_IDLE;
            end else begin
               state_s  = ST_BOOST;
               hv_cnt_s = HV_LOAD;
            end
         end else begin
            state_s = ST_SCAN;
         end
      end else begin
         hv_cnt_s = hv_cnt_s;
      end
   end

   // State and registered outputs; fault has priority over everything but reset.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cur_open_r <= '0;
         pending_r  <= '0;
         group_r    <= '0;
         idx_r      <= '0;
         rr_ptr_r   <= '0;
         scanned_r  <= '0;
         hv_cnt_r   <= 32'd0;
         gap_cnt_r  <= 32'd0;
         lv_on      <= '0;
         hv_on      <= '0;
         busy       <= 1'b0;
         backlog    <= '0;
      end else if (fault) begin
         state_r    <= ST_IDLE;
         cur_open_r <= '0;
         pending_r  <= '0;
         group_r    <= '0;
         idx_r      <= '0;
         rr_ptr_r   <= '0;
         scanned_r  <= '0;
         hv_cnt_r   <= 32'd0;
         gap_cnt_r  <= 32'd0;
         lv_on      <= '0;
         hv_on      <= '0;
         busy       <= 1'b0;
         backlog    <= '0;
      end else begin
         state_r    <= state_s;
         cur_open_r <= cur_open_s;
         pending_r  <= pending_s;
         group_r    <= group_s;
         idx_r      <= idx_s;
         rr_ptr_r   <= rr_ptr_s;
         scanned_r  <= scanned_s;
         hv_cnt_r   <= hv_cnt_s;
         gap_cnt_r  <= gap_cnt_s;
         lv_on      <= cur_open_s;
         hv_on      <= (state_s == ST_BOOST) ? (group_s & cur_open_s) : '0;
         busy       <= (state_s != ST_IDLE) || (pending_s != '0);
         backlog    <= popcount(pending_s);
      end
   end

endmodule
